// File: rtl/sbox_pkg.sv
// Shared definitions for the multi-lane AES S-box engine.
//
// The S-box is built in three layers so the parent can place pipeline cuts between them:
//   top    : linear. Applies the inverse affine map when ZF=1, then forms the seven Frobenius
//            powers t^2, t^4, ..., t^128. Squaring in GF(2^8) is linear, so this whole layer
//            is XOR logic.
//   middle : nonlinear. Multiplies the seven powers, giving t^254 = t^-1 (and 0 for t=0).
//   bottom : linear. Applies the forward affine map when ZF=0, and passes through when ZF=1.
package sbox_pkg;

    localparam logic SBOX_MODE_FWD = 1'b0;
    localparam logic SBOX_MODE_INV = 1'b1;

    // Top-layer intermediate: seven 8-bit Frobenius powers. Middle-layer intermediate: one byte.
    localparam int unsigned TOP_W = 56;
    localparam int unsigned MID_W = 8;

    typedef logic [7:0] lane_byte_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic lane_byte_t gf_mul(input lane_byte_t a, input lane_byte_t b);
        lane_byte_t p;
        lane_byte_t aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic lane_byte_t affine_fwd(input lane_byte_t a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]}
               ^ 8'h63;
    endfunction

    function automatic lane_byte_t affine_inv(input lane_byte_t a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/sbox_lane_core.sv
// One byte lane of the merged forward/inverse AES S-box, purely combinational.
//
// The three layers are exposed separately so the parent can register any of the boundaries:
//   data_i, top_zf_i -> top_o   (top linear layer)
//   top_i            -> mid_o   (nonlinear inversion)
//   mid_i, bot_zf_i  -> data_o  (bottom linear layer)
// With no cut, the parent connects top_o to top_i and mid_o to mid_i.
module sbox_lane_core
    import sbox_pkg::*;
(
    input  logic [7:0]       data_i,
    input  logic             top_zf_i,
    output logic [TOP_W-1:0] top_o,
    input  logic [TOP_W-1:0] top_i,
    output logic [MID_W-1:0] mid_o,
    input  logic [MID_W-1:0] mid_i,
    input  logic             bot_zf_i,
    output logic [7:0]       data_o
);

    lane_byte_t t;
    lane_byte_t sq [7];
    lane_byte_t p0, p1, p2, p3, p4;

    always_comb begin
        t = (top_zf_i == SBOX_MODE_INV) ? affine_inv(data_i) : data_i;
        sq[0] = gf_mul(t, t);
        for (int i = 1; i < 7; i++) begin
            sq[i] = gf_mul(sq[i-1], sq[i-1]);
        end
        top_o = {sq[6], sq[5], sq[4], sq[3], sq[2], sq[1], sq[0]};
    end

    // t^2 * t^4 * ... * t^128 = t^254, the field inverse.
    always_comb begin
        p0    = gf_mul(top_i[7:0], top_i[15:8]);
        p1    = gf_mul(top_i[23:16], top_i[31:24]);
        p2    = gf_mul(top_i[39:32], top_i[47:40]);
        p3    = gf_mul(p0, p1);
        p4    = gf_mul(p2, top_i[55:48]);
        mid_o = gf_mul(p3, p4);
    end

    always_comb begin
        data_o = (bot_zf_i == SBOX_MODE_INV) ? mid_i : affine_fwd(mid_i);
    end

endmodule

// File: rtl/sbox_lane_pipe.sv
// Pipelined multi-lane AES S-box engine with valid/ready handshake and full backpressure.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready depends on pipe state and out_ready only
//   in_inv               0 = forward S-box, 1 = inverse, shared by all lanes of a transaction
//   in_data, in_tag      LANES bytes (lane i = in_data[8i+7:8i]) and a user tag
//   out_valid/out_ready  output handshake; outputs hold while stalled
//   out_data, out_tag,
//   out_inv              result bytes, tag and direction of the transaction at the output
//   occupancy            number of valid stages in the pipe
//
// STAGES (1..3) places the registers: 1 = output only, 2 = after the top layer + output,
// 3 = after the top layer, after the middle layer, + output.
module sbox_lane_pipe
    import sbox_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_inv,
    input  logic [8*LANES-1:0]           in_data,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [8*LANES-1:0]           out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_inv,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q, v_d, adv, load, src_v;
    logic [STAGES-1:0] inv_q, inv_d, src_inv;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              hole;
    logic              accept, drain;

    // Stage k may load when it or any stage after it is empty, or the output drains.
    // Scanning from the output end keeps this free of combinational self-reference.
    always_comb begin
        adv  = '0;
        hole = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole   = hole || !v_q[k];
            adv[k] = hole;
        end
    end

    always_comb begin
        src_v[0]   = in_valid;
        src_inv[0] = in_inv;
        src_tag[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_inv[k] = inv_q[k-1];
            src_tag[k] = tag_q[k-1];
        end
        load = adv & src_v;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k]   = adv[k] ? src_v[k] : v_q[k];
            inv_d[k] = load[k] ? src_inv[k] : inv_q[k];
            tag_d[k] = load[k] ? src_tag[k] : tag_q[k];
        end
    end

    assign in_ready = adv[0];
    assign accept   = in_valid && adv[0];
    assign drain    = v_q[STAGES-1] && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (accept && !drain) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept && drain) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            inv_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            inv_q <= inv_d;
            occ_q <= occ_d;
            for (int k = 0; k < STAGES; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [TOP_W-1:0] top_c, top_s;
        logic [MID_W-1:0] mid_c, mid_s;
        logic [7:0]       res_c, res_d, res_q;

        // The bottom layer always works on whatever feeds the last stage.
        sbox_lane_core u_core (
            .data_i   (in_data[8*l +: 8]),
            .top_zf_i (in_inv),
            .top_o    (top_c),
            .top_i    (top_s),
            .mid_o    (mid_c),
            .mid_i    (mid_s),
            .bot_zf_i (src_inv[STAGES-1]),
            .data_o   (res_c)
        );

        if (STAGES >= 2) begin : g_top_cut
            logic [TOP_W-1:0] top_d, top_q;
            always_comb begin
                top_d = top_q;
                if (load[0]) begin
                    top_d = top_c;
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    top_q <= '0;
                end else begin
                    top_q <= top_d;
                end
            end
            assign top_s = top_q;
        end else begin : g_top_pass
            assign top_s = top_c;
        end

        if (STAGES >= 3) begin : g_mid_cut
            logic [MID_W-1:0] mid_d, mid_q;
            always_comb begin
                mid_d = mid_q;
                if (load[1]) begin
                    mid_d = mid_c;
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    mid_q <= '0;
                end else begin
                    mid_q <= mid_d;
                end
            end
            assign mid_s = mid_q;
        end else begin : g_mid_pass
            assign mid_s = mid_c;
        end

        always_comb begin
            res_d = res_q;
            if (load[STAGES-1]) begin
                res_d = res_c;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                res_q <= '0;
            end else begin
                res_q <= res_d;
            end
        end

        assign out_data[8*l +: 8] = res_q;
    end

    assign out_valid = v_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_inv   = inv_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
